// File: rtl/alu_flag_pkg.sv
// Shared constants for the ALU flag path: flag bit positions, flag width and
// the branch condition encodings used by the flag register and the sequencer.
package alu_flag_pkg;

  localparam int unsigned FLAGS_W = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_N      = 3'd5,
    COND_V      = 3'd6,
    COND_UGT    = 3'd7
  } cond_e;

  typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/alu_flag_cond_eval.sv
// Combinational branch-condition evaluator: (cond_sel, flags) -> take_c.
// Shared with the sequencer, so it holds no state.
module alu_flag_cond_eval
  import alu_flag_pkg::*;
(
  input  logic [2:0] cond_sel,
  input  flags_t     flags,
  output logic       take_c
);

  always_comb begin
    take_c = 1'b0;
    case (cond_e'(cond_sel))
      COND_ALWAYS: take_c = 1'b1;
      COND_Z:      take_c = flags[FLAG_Z];
      COND_NZ:     take_c = ~flags[FLAG_Z];
      COND_C:      take_c = flags[FLAG_C];
      COND_NC:     take_c = ~flags[FLAG_C];
      COND_N:      take_c = flags[FLAG_N];
      COND_V:      take_c = flags[FLAG_V];
      COND_UGT:    take_c = flags[FLAG_C] & ~flags[FLAG_Z];
      default:     take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_register.sv
// ALU flag register with multi-byte Z chaining and a registered branch condition.
// Optional flag-save stack built when ALU_FLAG_STACK_EN is defined.
module alu_flag_register
  import alu_flag_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flag_we,
  input  logic [3:0]   flag_mask,
  input  logic         chain,
  input  logic         z_in,
  input  logic         c_in,
  input  logic         n_in,
  input  logic         v_in,
  input  logic         cond_req,
  input  logic [2:0]   cond_sel,
  output logic         take,
  output logic         take_valid,
  output logic [3:0]   flags_q,
  input  logic         push,
  input  logic         pop,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         stack_err
);

  flags_t flags_wr_c;
  flags_t flags_d;
  logic   take_c;

  // Masked flag write; chaining ANDs the new zero into the running Z.
  always_comb begin
    flags_wr_c = flags_q;
    if (flag_we) begin
      if (flag_mask[FLAG_Z]) flags_wr_c[FLAG_Z] = chain ? (z_in & flags_q[FLAG_Z]) : z_in;
      if (flag_mask[FLAG_C]) flags_wr_c[FLAG_C] = c_in;
      if (flag_mask[FLAG_N]) flags_wr_c[FLAG_N] = n_in;
      if (flag_mask[FLAG_V]) flags_wr_c[FLAG_V] = v_in;
    end
  end

`ifdef ALU_FLAG_STACK_EN
  localparam int unsigned STACK_W = STACK_DEPTH * FLAGS_W;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  // Entry 0 (low nibble) is always the top of stack; push/pop shift the vector.
  logic [STACK_W-1:0] stack_q, stack_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full_q, empty_q, err_q, err_d;

  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    err_d   = err_q;
    flags_d = flags_wr_c;
    if (push && !pop) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        stack_d = (stack_q << FLAGS_W) | STACK_W'(flags_q);
        depth_d = depth_q + DEPTH_W'(1);
      end
    end else if (pop && !push) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        flags_d = stack_q[FLAGS_W-1:0];
        stack_d = stack_q >> FLAGS_W;
        depth_d = depth_q - DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q <= '0;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      full_q  <= (depth_d == DEPTH_W'(STACK_DEPTH));
      empty_q <= (depth_d == '0);
      err_q   <= err_d;
    end
  end

  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;
`else
  logic unused_stack_c;

  assign unused_stack_c = ^{push, pop, 1'(STACK_DEPTH % 2)};
  assign flags_d        = flags_wr_c;
  assign stack_full     = 1'b0;
  assign stack_empty    = 1'b1;
  assign stack_err      = 1'b0;
`endif

  // Condition sees the same-cycle update so branches never stall on flags.
  alu_flag_cond_eval u_cond_eval (
    .cond_sel (cond_sel),
    .flags    (flags_d),
    .take_c   (take_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      take       <= 1'b0;
      take_valid <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      take_valid <= cond_req;
      if (cond_req) take <= take_c;
    end
  end

endmodule

// File: tb/tb_alu_flag_register.sv
// Directed self-checking bench for alu_flag_register; stack scenarios are
// exercised when ALU_FLAG_STACK_EN is defined, tie-offs otherwise.
module tb_alu_flag_register;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flag_mask;
  logic       chain;
  logic       z_in, c_in, n_in, v_in;
  logic       cond_req;
  logic [2:0] cond_sel;
  logic       take, take_valid;
  logic [3:0] flags_q;
  logic       push, pop;
  logic       stack_full, stack_empty, stack_err;

  int vectors;
  int miscompares;

  // {expected take, cond_sel, flags {V,N,C,Z}}
  logic [7:0] cc_tbl [17] = '{
    {1'b1, 3'd7, 4'b0010}, {1'b0, 3'd7, 4'b0011}, {1'b0, 3'd7, 4'b0000},
    {1'b1, 3'd0, 4'b0000}, {1'b1, 3'd0, 4'b1111},
    {1'b1, 3'd1, 4'b0001}, {1'b0, 3'd1, 4'b0000},
    {1'b1, 3'd2, 4'b0000}, {1'b0, 3'd2, 4'b0001},
    {1'b1, 3'd3, 4'b0010}, {1'b0, 3'd3, 4'b1101},
    {1'b1, 3'd4, 4'b0000}, {1'b0, 3'd4, 4'b0010},
    {1'b1, 3'd5, 4'b0100}, {1'b0, 3'd5, 4'b1011},
    {1'b1, 3'd6, 4'b1000}, {1'b0, 3'd6, 4'b0111}
  };

  alu_flag_register #(.STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
    .chain(chain), .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
    .cond_req(cond_req), .cond_sel(cond_sel), .take(take), .take_valid(take_valid),
    .flags_q(flags_q), .push(push), .pop(pop), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flag_we = 1'b0; flag_mask = 4'h0; chain = 1'b0;
    {v_in, n_in, c_in, z_in} = 4'h0;
    cond_req = 1'b0; cond_sel = 3'd0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic write_flags(input logic [3:0] f);
    flag_we = 1'b1; flag_mask = 4'hF; chain = 1'b0;
    {v_in, n_in, c_in, z_in} = f;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({flags_q, take, take_valid} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_regs: flags/take/valid=%b expected 000000", {flags_q, take, take_valid});
    end
    vectors++;
    if ({stack_full, stack_empty, stack_err} !== 3'b010) begin
      miscompares++;
      $display("FAIL reset_stack: full/empty/err=%b expected 010", {stack_full, stack_empty, stack_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_mask();
    logic [3:0] mask [5] = '{4'hF, 4'h4, 4'h2, 4'hF, 4'h8};
    logic [3:0] din  [5] = '{4'b1011, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    logic       we   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp  [5] = '{4'b1011, 4'b1111, 4'b1101, 4'b1101, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      flag_we = we[i]; flag_mask = mask[i]; chain = 1'b0;
      {v_in, n_in, c_in, z_in} = din[i];
      @(posedge clk); #1;
      idle();
      vectors++;
      if (flags_q !== exp[i]) begin
        miscompares++;
        $display("FAIL write_mask[%0d]: flags_q=%b expected %b", i, flags_q, exp[i]);
      end
    end
  endtask

  task automatic test_chain();
    // {chain, mask, z_in, expected Z}
    logic [6:0] seq [6] = '{
      {1'b0, 4'h1, 1'b1, 1'b1}, {1'b1, 4'h1, 1'b0, 1'b0}, {1'b1, 4'h1, 1'b1, 1'b0},
      {1'b0, 4'h1, 1'b1, 1'b1}, {1'b1, 4'h2, 1'b0, 1'b1}, {1'b1, 4'h1, 1'b1, 1'b1}
    };
    for (int i = 0; i < 6; i++) begin
      flag_we = 1'b1; chain = seq[i][6]; flag_mask = seq[i][5:2]; z_in = seq[i][1];
      @(posedge clk); #1;
      idle();
      vectors++;
      if (flags_q[0] !== seq[i][0]) begin
        miscompares++;
        $display("FAIL chain[%0d]: Z=%b expected %b", i, flags_q[0], seq[i][0]);
      end
    end
  endtask

  task automatic test_forwarding();
    write_flags(4'b0000);
    flag_we = 1'b1; flag_mask = 4'h1; z_in = 1'b1;
    cond_req = 1'b1; cond_sel = 3'd1;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({take, take_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL forward: take/valid=%b expected 11", {take, take_valid});
    end
    @(posedge clk); #1;
    vectors++;
    if ({take, take_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL forward_drop: take/valid=%b expected 10", {take, take_valid});
    end
  endtask

  task automatic test_cond_codes();
    for (int i = 0; i < 17; i++) begin
      write_flags(cc_tbl[i][3:0]);
      cond_req = 1'b1; cond_sel = cc_tbl[i][6:4];
      @(posedge clk); #1;
      idle();
      vectors++;
      if ({take, take_valid} !== {cc_tbl[i][7], 1'b1}) begin
        miscompares++;
        $display("FAIL cond[%0d] sel=%0d flags=%b: take/valid=%b expected %b1",
                 i, cc_tbl[i][6:4], cc_tbl[i][3:0], {take, take_valid}, cc_tbl[i][7]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] sel [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
    logic       exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    write_flags(4'b0011);
    for (int i = 0; i < 6; i++) begin
      cond_req = 1'b1; cond_sel = sel[i];
      @(posedge clk); #1;
      vectors++;
      if ({take, take_valid} !== {exp[i], 1'b1}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: take/valid=%b expected %b1", i, {take, take_valid}, exp[i]);
      end
    end
    idle();
    @(posedge clk); #1;
    vectors++;
    if ({take, take_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_end: take/valid=%b expected 10", {take, take_valid});
    end
  endtask

`ifdef ALU_FLAG_STACK_EN
  task automatic test_stack();
    logic [3:0] vals [4] = '{4'h3, 4'h5, 4'hA, 4'hC};
    // push and pop together on an empty stack: no stack op, write still applies
    push = 1'b1; pop = 1'b1; flag_we = 1'b1; flag_mask = 4'hF;
    {v_in, n_in, c_in, z_in} = 4'h9;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({flags_q, stack_empty, stack_err} !== {4'h9, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL push_pop: flags/empty/err=%b expected 100110", {flags_q, stack_empty, stack_err});
    end
    for (int k = 0; k < 4; k++) begin
      write_flags(vals[k]);
      push = 1'b1;
      @(posedge clk); #1;
      idle();
      vectors++;
      if ({stack_full, stack_empty} !== {(k == 3), 1'b0}) begin
        miscompares++;
        $display("FAIL push[%0d]: full/empty=%b expected %b0", k, {stack_full, stack_empty}, (k == 3));
      end
    end
    write_flags(4'h6);
    push = 1'b1;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({flags_q, stack_full, stack_err} !== {4'h6, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL push_full: flags/full/err=%b expected 011011", {flags_q, stack_full, stack_err});
    end
    for (int k = 3; k >= 0; k--) begin
      pop = 1'b1;
      if (k == 3) begin
        flag_we = 1'b1; flag_mask = 4'hF; {v_in, n_in, c_in, z_in} = 4'hF;
      end
      @(posedge clk); #1;
      idle();
      vectors++;
      if ({flags_q, stack_full, stack_empty} !== {vals[k], 1'b0, (k == 0)}) begin
        miscompares++;
        $display("FAIL pop[%0d]: flags/full/empty=%b expected %b0%b",
                 k, {flags_q, stack_full, stack_empty}, vals[k], (k == 0));
      end
    end
    pop = 1'b1;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({flags_q, stack_empty, stack_err} !== {4'h3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL pop_empty: flags/empty/err=%b expected 001111", {flags_q, stack_empty, stack_err});
    end
  endtask
`else
  task automatic test_stack();
    write_flags(4'h5);
    push = 1'b1;
    @(posedge clk); #1;
    idle();
    write_flags(4'hA);
    pop = 1'b1;
    @(posedge clk); #1;
    idle();
    pop = 1'b1;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({flags_q, stack_full, stack_empty, stack_err} !== {4'hA, 3'b010}) begin
      miscompares++;
      $display("FAIL stack_tieoff: flags/full/empty/err=%b expected 1010010",
               {flags_q, stack_full, stack_empty, stack_err});
    end
  endtask
`endif

  task automatic test_async_reset();
    write_flags(4'hF);
    push = 1'b1;
    @(posedge clk); #1;
    push = 1'b1; cond_req = 1'b1; cond_sel = 3'd0;
    @(posedge clk); #1;
    idle();
    vectors++;
    if ({flags_q, take, take_valid} !== 6'b111111) begin
      miscompares++;
      $display("FAIL pre_reset: flags/take/valid=%b expected 111111", {flags_q, take, take_valid});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({flags_q, take, take_valid, stack_full, stack_empty, stack_err} !== 9'b000000010) begin
      miscompares++;
      $display("FAIL async_reset: flags/take/valid/full/empty/err=%b expected 000000010",
               {flags_q, take, take_valid, stack_full, stack_empty, stack_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    flag_we = 1'b1; flag_mask = 4'h1; chain = 1'b1; z_in = 1'b1;
    @(posedge clk); #1;
    idle();
    vectors++;
    if (flags_q !== 4'b0000) begin
      miscompares++;
      $display("FAIL chain_after_reset: flags_q=%b expected 0000", flags_q);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_write_mask();
    test_chain();
    test_forwarding();
    test_cond_codes();
    test_back_to_back();
    test_stack();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
